// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the 8-bit UART receiver: 16x oversample tick
// generation, ready/ready_clr servicing, byte FIFO and sticky overflow flag.
module uart_rx_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 27,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic [DIV_WIDTH-1:0]               cfg_div,
    input  logic                               cfg_load,
    input  logic                               rx_ready,
    input  logic [7:0]                         rx_data,
    output logic                               rx_en,
    output logic                               ready_clr,
    output logic                               m_valid,
    output logic [7:0]                         m_data,
    input  logic                               m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow,
    input  logic                               clr_overflow,
    output logic [1:0]                         dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d, div_eff;
    logic                 rx_en_q, rx_en_d;
    state_t               state_q, state_d;
    logic                 ready_clr_q, ready_clr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic                 capture, push, pop, drop;

    // A divisor of zero would never wrap; treat it as one (tick every cycle).
    assign div_eff = (div_q == '0) ? DIV_WIDTH'(1) : div_q;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        rx_en_d = 1'b0;
        if (cfg_load) begin
            div_d = cfg_div;
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == div_eff - DIV_WIDTH'(1)) begin
                cnt_d   = '0;
                rx_en_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Downstream stream: a byte transfers on a rising edge where m_valid and
    // m_ready are both high; m_valid/m_data depend only on FIFO state.
    assign capture = (state_q == ST_IDLE) && rx_ready;
    assign pop     = m_valid && m_ready;
    assign push    = capture && ((count_q != DEPTH_C) || pop);
    assign drop    = capture && !push;

    always_comb begin
        state_d     = state_q;
        ready_clr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    state_d     = ST_ACK;
                    ready_clr_d = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            // Guard cycle so a rx_ready not yet cleared is not taken twice.
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (clr_overflow) ovf_d = 1'b0;
        if (drop)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q       <= '0;
            rx_en_q     <= 1'b0;
            state_q     <= ST_IDLE;
            ready_clr_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            rx_en_q     <= rx_en_d;
            state_q     <= state_d;
            ready_clr_q <= ready_clr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rx_en      = rx_en_q;
    assign ready_clr  = ready_clr_q;
    assign m_valid    = (count_q != '0);
    assign m_data     = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick generator, byte capture handshake,
// FIFO ordering/overflow/wrap and asynchronous reset.
module tb_uart_rx_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_load = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_en, ready_clr, m_valid, overflow;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        clr_overflow = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_ctrl #(.DIV_WIDTH(16), .DEFAULT_DIV(27), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_div(cfg_div),
        .cfg_load(cfg_load), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_en(rx_en), .ready_clr(ready_clr), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .fifo_count(fifo_count),
        .overflow(overflow), .clr_overflow(clr_overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Scoreboard: every accepted byte must match the head of exp_q.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            check("pop_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Receiver model: raise ready with a byte, drop it once ready_clr is seen.
    task automatic send_byte(input logic [7:0] b);
        int pulses = 0;
        int first = -1;
        rx_ready = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (ready_clr) begin
                pulses++;
                if (first < 0) first = k;
                rx_ready = 1'b0;
            end
        end
        check("clr_pulses", 32'(pulses), 1);
        check("clr_latency", 32'(first), 0);
    endtask

    task automatic count_ticks(input int n, output int cnt, output int first, output int second);
        cnt = 0; first = -1; second = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (rx_en) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
    endtask

    initial begin
        int cnt, first, second;

        #12;
        check("rst_rx_en", 32'(rx_en), 0);
        check("rst_ready_clr", 32'(ready_clr), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        step(1);
        reset_n = 1'b1;
        step(2);

        // Tick generator with the reset divisor of 27
        enable = 1'b1;
        count_ticks(60, cnt, first, second);
        check("tick27_first", 32'(first), 27);
        check("tick27_period", 32'(second - first), 27);
        check("tick27_count", 32'(cnt), 2);

        cfg_div = 16'd4; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        check("load_rx_en", 32'(rx_en), 0);
        count_ticks(12, cnt, first, second);
        check("tick4_first", 32'(first), 4);
        check("tick4_period", 32'(second - first), 4);
        check("tick4_count", 32'(cnt), 3);

        cfg_div = 16'd0; cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        count_ticks(5, cnt, first, second);
        check("tick0_count", 32'(cnt), 5);
        enable = 1'b0;
        step(1);
        check("disable_rx_en", 32'(rx_en), 0);

        // Single byte
        send_byte(8'hA5);
        check("single_valid", 32'(m_valid), 1);
        check("single_data", 32'(m_data), 'hA5);
        check("single_count", 32'(fifo_count), 1);
        exp_q.push_back(8'hA5);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        check("single_popped", 32'(fifo_count), 0);
        check("single_empty", 32'(m_valid), 0);

        // Overflow: fifth byte is dropped but still acknowledged
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("ovf_count", 32'(fifo_count), 4);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(m_data), 'h01);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        m_ready = 1'b1;
        step(4);
        m_ready = 1'b0;
        check("ovf_drained", 32'(fifo_count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
        check("full_count", 32'(fifo_count), 4);
        exp_q.push_back(8'h10);
        rx_ready = 1'b1; rx_data = 8'h14; m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        check("pp_ready_clr", 32'(ready_clr), 1);
        rx_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 4);
        check("pp_head", 32'(m_data), 'h11);
        check("pp_overflow", 32'(overflow), 0);
        step(3);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(8'h10 + i));
        m_ready = 1'b1;
        step(4);
        m_ready = 1'b0;
        check("pp_drained", 32'(fifo_count), 0);
        check("pp_overflow_end", 32'(overflow), 0);

        // Wrap-around with continuous m_ready
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            send_byte(8'(8'h20 + i));
        end
        step(2);
        m_ready = 1'b0;
        check("wrap_count", 32'(fifo_count), 0);
        check("wrap_all_seen", 32'(exp_q.size()), 0);

        // Async reset during ACK with two bytes queued
        send_byte(8'h31);
        send_byte(8'h32);
        check("pre_rst_count", 32'(fifo_count), 2);
        rx_ready = 1'b1; rx_data = 8'h33;
        @(posedge clk);
        #2;
        check("pre_rst_state_ack", 32'(dbg_state), 1);
        reset_n = 1'b0;
        #1;
        check("arst_ready_clr", 32'(ready_clr), 0);
        check("arst_m_valid", 32'(m_valid), 0);
        check("arst_count", 32'(fifo_count), 0);
        check("arst_rx_en", 32'(rx_en), 0);
        check("arst_overflow", 32'(overflow), 0);
        rx_ready = 1'b0;
        step(2);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ready_clr) cnt++;
            check("post_rst_valid", 32'(m_valid), 0);
        end
        check("post_rst_no_clr", 32'(cnt), 0);
        send_byte(8'h5A);
        check("post_rst_data", 32'(m_data), 'h5A);
        check("post_rst_count", 32'(fifo_count), 1);
        exp_q.push_back(8'h5A);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        check("post_rst_popped", 32'(fifo_count), 0);

        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
